// File: rtl/overcooked_pkg.sv
// Shared types and constants for the Overcooked order/points controller.
// Holds the dish encoding, slot/player counts, score ceiling and LFSR helpers.
package overcooked_pkg;

    typedef enum logic [1:0] {
        DISH_SALAD  = 2'd0,
        DISH_SOUP   = 2'd1,
        DISH_BURGER = 2'd2,
        DISH_PASTA  = 2'd3
    } dish_t;

    localparam int NUM_ORDER_SLOTS = 4;
    localparam int NUM_PLAYERS     = 4;
    localparam int SCORE_MAX       = 1023;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    function automatic logic [7:0] lfsr_advance(input logic [7:0] state);
        return {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: combinational one-hot grant, pointer moves to
// the player after the winner whenever a grant is issued.
module rr_arbiter4
    import overcooked_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_PLAYERS-1:0] req,
    input  logic                   advance,
    output logic [NUM_PLAYERS-1:0] grant
);

    logic [1:0] ptr_reg;
    logic [1:0] ptr_next;
    logic [1:0] idx;

    always_comb begin
        grant    = '0;
        ptr_next = ptr_reg;
        idx      = ptr_reg;
        if (advance) begin
            for (int k = 0; k < NUM_PLAYERS; k++) begin
                idx = ptr_reg + 2'(k);
                if (req[idx] && grant == '0) begin
                    grant[idx] = 1'b1;
                    ptr_next   = idx + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_reg <= 2'd0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/order_scheduler.sv
// Order slots, spawn/aging cadence, delivery matching and team score.
// Optional: define EXPIRE_PENALTY_EN to deduct EXPIRE_PENALTY per expired order.
module order_scheduler
    import overcooked_pkg::*;
#(
    parameter int ORDER_TIME      = 30,
    parameter int SPAWN_INTERVAL  = 10,
    parameter int DELIVERY_POINTS = 20,
    parameter int EXPIRE_PENALTY  = 10
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  running,
    input  logic                                  tick_1hz,
    input  logic [NUM_PLAYERS-1:0]                deliver_req,
    input  logic [NUM_PLAYERS-1:0][1:0]           deliver_dish,
    output logic [NUM_PLAYERS-1:0]                deliver_ack,
    output logic                                  deliver_hit,
    output logic [NUM_ORDER_SLOTS-1:0]            orders,
    output logic [NUM_ORDER_SLOTS-1:0][1:0]       order_types,
    output logic [NUM_ORDER_SLOTS-1:0][4:0]       order_times,
    output logic [9:0]                            point_total
);

`ifdef EXPIRE_PENALTY_EN
    localparam bit PENALTY_ON = 1'b1;
`else
    localparam bit PENALTY_ON = 1'b0;
`endif
    localparam int PENALTY = PENALTY_ON ? EXPIRE_PENALTY : 0;

    localparam logic [7:0]                 SPAWN_WRAP = 8'(SPAWN_INTERVAL - 1);
    localparam logic [4:0]                 TIME_INIT  = 5'(ORDER_TIME);
    localparam logic [NUM_ORDER_SLOTS-1:0] SLOT_ONE   = NUM_ORDER_SLOTS'(1);

    logic [NUM_ORDER_SLOTS-1:0]      valid_reg, valid_next;
    logic [NUM_ORDER_SLOTS-1:0][1:0] type_reg,  type_next;
    logic [NUM_ORDER_SLOTS-1:0][4:0] time_reg,  time_next;
    logic [9:0]                      score_reg, score_next;
    logic [7:0]                      spawn_cnt_reg, spawn_cnt_next;
    logic [7:0]                      lfsr_reg;
    logic [NUM_PLAYERS-1:0]          ack_reg;
    logic                            hit_reg;

    logic                            tick_en;
    logic                            spawn_now;
    logic [NUM_PLAYERS-1:0]          grant;
    logic                            gnt_any;
    logic [1:0]                      gnt_idx;
    dish_t                           gnt_dish;
    logic [NUM_ORDER_SLOTS-1:0]      match;
    logic                            hit;
    logic [NUM_ORDER_SLOTS-1:0]      hit_mask;
    logic [NUM_ORDER_SLOTS-1:0]      free_mask;
    logic [NUM_ORDER_SLOTS-1:0]      spawn_mask;
    logic [NUM_ORDER_SLOTS-1:0]      expire;
    logic [NUM_ORDER_SLOTS-1:0]      clear;
    logic [NUM_ORDER_SLOTS-1:0]      age;
    int                              n_expired;
    int                              score_sum;

    assign tick_en   = tick_1hz && running;
    assign spawn_now = tick_en && (spawn_cnt_reg == SPAWN_WRAP);

    rr_arbiter4 u_arbiter (
        .clock   (clock),
        .reset   (reset),
        .req     (deliver_req),
        .advance (running),
        .grant   (grant)
    );

    assign gnt_any = |grant;

    always_comb begin
        gnt_idx = 2'd0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            if (grant[k]) begin
                gnt_idx = 2'(k);
            end
        end
    end

    assign gnt_dish = dish_t'(deliver_dish[gnt_idx]);

    // All matching and slot selection looks at pre-update state, so a slot
    // freed this cycle is never refilled until the next one.
    assign hit        = gnt_any && (|match);
    assign hit_mask   = hit ? (match & (~match + SLOT_ONE)) : '0;
    assign free_mask  = ~valid_reg;
    assign spawn_mask = spawn_now ? (free_mask & (~free_mask + SLOT_ONE)) : '0;

    generate
        for (genvar gi = 0; gi < NUM_ORDER_SLOTS; gi++) begin : g_slot
            assign match[gi]  = valid_reg[gi] && (dish_t'(type_reg[gi]) == gnt_dish);
            assign expire[gi] = tick_en && valid_reg[gi] && (time_reg[gi] == 5'd1);
            assign age[gi]    = tick_en && valid_reg[gi];
            assign clear[gi]  = hit_mask[gi] || expire[gi];

            assign valid_next[gi] = clear[gi]      ? 1'b0 :
                                    spawn_mask[gi] ? 1'b1 : valid_reg[gi];
            assign type_next[gi]  = clear[gi]      ? 2'd0 :
                                    spawn_mask[gi] ? lfsr_reg[1:0] : type_reg[gi];
            assign time_next[gi]  = clear[gi]      ? 5'd0 :
                                    spawn_mask[gi] ? TIME_INIT :
                                    age[gi]        ? time_reg[gi] - 5'd1 : time_reg[gi];
        end
    endgenerate

    // A slot delivered in the same cycle it would expire counts as a hit only.
    always_comb begin
        n_expired = 0;
        for (int k = 0; k < NUM_ORDER_SLOTS; k++) begin
            if (expire[k] && !hit_mask[k]) begin
                n_expired = n_expired + 1;
            end
        end
    end

    // Delivery points saturate first; expiry penalties are applied afterwards.
    always_comb begin
        score_sum = int'(score_reg);
        if (hit) begin
            score_sum = score_sum + DELIVERY_POINTS;
        end
        if (score_sum > SCORE_MAX) begin
            score_sum = SCORE_MAX;
        end
        score_sum = score_sum - n_expired * PENALTY;
        if (score_sum < 0) begin
            score_sum = 0;
        end
        score_next = 10'(score_sum);
    end

    always_comb begin
        spawn_cnt_next = spawn_cnt_reg;
        if (tick_en) begin
            spawn_cnt_next = (spawn_cnt_reg == SPAWN_WRAP) ? 8'd0 : spawn_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_reg     <= '0;
            type_reg      <= '0;
            time_reg      <= '0;
            score_reg     <= '0;
            spawn_cnt_reg <= SPAWN_WRAP;
            lfsr_reg      <= LFSR_SEED;
            ack_reg       <= '0;
            hit_reg       <= 1'b0;
        end else begin
            valid_reg     <= valid_next;
            type_reg      <= type_next;
            time_reg      <= time_next;
            score_reg     <= score_next;
            spawn_cnt_reg <= spawn_cnt_next;
            lfsr_reg      <= lfsr_advance(lfsr_reg);
            ack_reg       <= grant;
            hit_reg       <= hit;
        end
    end

    assign deliver_ack = ack_reg;
    assign deliver_hit = hit_reg;
    assign orders      = valid_reg;
    assign order_types = type_reg;
    assign order_times = time_reg;
    assign point_total = score_reg;

endmodule

// File: tb/tb_order_scheduler.sv
// Directed bench for order_scheduler: a small slot/score model plus a queue of
// expected delivery acks, checked with immediate assertions.
module tb_order_scheduler;

    localparam int OT = 31;
    localparam int SI = 3;
    localparam int DP = 20;
    localparam int EP = 10;

    logic            clock = 1'b0;
    logic            reset;
    logic            running;
    logic            tick_1hz;
    logic [3:0]      deliver_req;
    logic [3:0][1:0] deliver_dish;
    logic [3:0]      deliver_ack;
    logic            deliver_hit;
    logic [3:0]      orders;
    logic [3:0][1:0] order_types;
    logic [3:0][4:0] order_times;
    logic [9:0]      point_total;

    always #5 clock = ~clock;

    order_scheduler #(
        .ORDER_TIME      (OT),
        .SPAWN_INTERVAL  (SI),
        .DELIVERY_POINTS (DP),
        .EXPIRE_PENALTY  (EP)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .running      (running),
        .tick_1hz     (tick_1hz),
        .deliver_req  (deliver_req),
        .deliver_dish (deliver_dish),
        .deliver_ack  (deliver_ack),
        .deliver_hit  (deliver_hit),
        .orders       (orders),
        .order_types  (order_types),
        .order_times  (order_times),
        .point_total  (point_total)
    );

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [3:0] ack;
        logic       hit;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state
    logic [7:0] m_lfsr;
    bit         m_valid[4];
    logic [1:0] m_type[4];
    int         m_time[4];
    int         m_score;
    int         m_cnt;

    always @(posedge clock) begin
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_type[i]  = 2'd0;
            m_time[i]  = 0;
        end
        m_score = 0;
        m_cnt   = SI - 1;
    endtask

    function automatic int find_match(input logic [1:0] d);
        for (int i = 0; i < 4; i++) begin
            if (m_valid[i] && m_type[i] == d) return i;
        end
        return -1;
    endfunction

    function automatic int find_due();
        for (int i = 0; i < 4; i++) begin
            if (m_valid[i] && m_time[i] == 1) return i;
        end
        return -1;
    endfunction

    // Advance the model by one clock; call before the edge so m_lfsr is the
    // value the DUT samples.
    task automatic model_cycle(input bit do_tick, input int hit_slot);
        int  free_slot;
        int  n_exp;
        bit  spawn;
        free_slot = -1;
        n_exp     = 0;
        spawn     = 1'b0;
        if (do_tick) begin
            for (int i = 0; i < 4; i++) begin
                if (!m_valid[i] && free_slot < 0) free_slot = i;
            end
            spawn = (m_cnt == SI - 1);
            m_cnt = spawn ? 0 : m_cnt + 1;
            for (int i = 0; i < 4; i++) begin
                if (m_valid[i]) begin
                    if (m_time[i] == 1) begin
                        if (i != hit_slot) n_exp++;
                        m_valid[i] = 1'b0;
                        m_type[i]  = 2'd0;
                        m_time[i]  = 0;
                    end else begin
                        m_time[i] = m_time[i] - 1;
                    end
                end
            end
            if (spawn && free_slot >= 0) begin
                m_valid[free_slot] = 1'b1;
                m_type[free_slot]  = m_lfsr[1:0];
                m_time[free_slot]  = OT;
            end
        end
        if (hit_slot >= 0) begin
            m_valid[hit_slot] = 1'b0;
            m_type[hit_slot]  = 2'd0;
            m_time[hit_slot]  = 0;
            m_score = (m_score + DP > 1023) ? 1023 : m_score + DP;
        end
`ifdef EXPIRE_PENALTY_EN
        m_score = m_score - n_exp * EP;
        if (m_score < 0) m_score = 0;
`endif
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s.valid%0d", tag, i), 32'(orders[i]), 32'(m_valid[i]));
            check($sformatf("%s.type%0d", tag, i), 32'(order_types[i]), 32'(m_type[i]));
            check($sformatf("%s.time%0d", tag, i), 32'(order_times[i]), m_time[i]);
        end
        check({tag, ".score"}, 32'(point_total), m_score);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_once(input string tag);
        tick_1hz = 1'b1;
        if (running) model_cycle(1'b1, -1);
        step();
        tick_1hz = 1'b0;
        check({tag, ".ack"}, 32'(deliver_ack), 0);
        check_state(tag);
    endtask

    // Called one cycle after the request was sampled; waited counts extra cycles.
    task automatic wait_ack(input string tag, input int budget, output int waited);
        exp_t e;
        waited = 0;
        while (deliver_ack == 4'd0 && waited < budget) begin
            step();
            waited++;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, ".ack"}, 32'(deliver_ack), 32'(e.ack));
            check({tag, ".hit"}, 32'(deliver_hit), 32'(e.hit));
        end else begin
            check({tag, ".queue"}, 32'(deliver_ack), 0);
        end
        $display("delivery %s: ack=%b hit=%b score=%0d", tag, deliver_ack, deliver_hit, point_total);
    endtask

    task automatic deliver(input string tag, input int p, input logic [1:0] dish, input bit with_tick);
        int hs;
        int w;
        hs = find_match(dish);
        exp_q.push_back(exp_t'({4'(1 << p), hs >= 0}));
        deliver_dish[p] = dish;
        deliver_req[p]  = 1'b1;
        if (with_tick) tick_1hz = 1'b1;
        model_cycle(with_tick, hs);
        step();
        tick_1hz = 1'b0;
        wait_ack(tag, 4, w);
        check({tag, ".latency"}, w, 0);
        deliver_req[p] = 1'b0;
        check_state(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        int         s;
        int         n;
        int         pre;
        logic [1:0] absent;

        reset        = 1'b1;
        running      = 1'b0;
        tick_1hz     = 1'b0;
        deliver_req  = 4'd0;
        deliver_dish = '0;
        model_reset();
        repeat (3) step();
        reset = 1'b0;
        check("reset.orders", 32'(orders), 0);
        check("reset.types", 32'(order_types), 0);
        check("reset.times", 32'(order_times), 0);
        check("reset.score", 32'(point_total), 0);
        check("reset.ack", 32'(deliver_ack), 0);
        check("reset.hit", 32'(deliver_hit), 0);

        // First in-play tick spawns into slot 0
        running = 1'b1;
        tick_once("first_tick");
        check("first_tick.mask", 32'(orders), 32'h1);
        check("first_tick.time0", 32'(order_times[0]), OT);

        // Fill all four slots; the fifth spawn (tick 13) is dropped
        for (int t = 2; t <= 13; t++) tick_once($sformatf("fill%0d", t));
        check("fill.mask", 32'(orders), 32'hF);
        check("fill.time0", 32'(order_times[0]), OT - 12);

        // Player 1 delivers the dish that slot 0 wants
        deliver("hit_p1", 1, m_type[0], 1'b0);
        check("hit_p1.points", 32'(point_total), DP);
        check("hit_p1.mask", 32'(orders), 32'hE);

        // Pick a dish that no open order wants
        absent = 2'd0;
        for (int d = 3; d >= 0; d--) begin
            if (find_match(2'(d)) < 0) absent = 2'(d);
        end

        // Player 3 misses, leaving the round-robin pointer at player 0
        deliver("miss_p3", 3, absent, 1'b0);

        // All four players miss: acks in order 0,1,2,3 on consecutive cycles
        deliver_dish = {absent, absent, absent, absent};
        deliver_req  = 4'hF;
        for (int p = 0; p < 4; p++) exp_q.push_back(exp_t'({4'(1 << p), 1'b0}));
        step();
        for (int k = 0; k < 4; k++) begin
            wait_ack($sformatf("rr%0d", k), 4, w);
            check($sformatf("rr%0d.latency", k), w, 0);
            deliver_req = deliver_req & ~deliver_ack;
            if (k < 3) step();
        end
        step();
        check("rr.idle_ack", 32'(deliver_ack), 0);
        check_state("rr");

        // running low freezes everything and withholds the grant
        running         = 1'b0;
        deliver_dish[2] = m_type[3];
        deliver_req[2]  = 1'b1;
        for (int t = 0; t < 3; t++) tick_once($sformatf("frozen%0d", t));
        pre = find_match(deliver_dish[2]);
        exp_q.push_back(exp_t'({4'b0100, pre >= 0}));
        running = 1'b1;
        model_cycle(1'b0, pre);
        step();
        wait_ack("resume_p2", 4, w);
        check("resume_p2.latency", w, 0);
        deliver_req[2] = 1'b0;
        check_state("resume_p2");

        // Delivery on the cycle a slot would expire: hit wins, no penalty
        s = find_due();
        n = 0;
        while (s < 0 && n < 40) begin
            tick_once("age_wait");
            n++;
            s = find_due();
        end
        if (s >= 0) begin
            n = 0;
            while (find_match(m_type[s]) != s && n < 4) begin
                deliver("clear_lower", 0, m_type[s], 1'b0);
                n++;
            end
            pre = m_score;
            deliver("hit_expire", 1, m_type[s], 1'b1);
            check("hit_expire.points", 32'(point_total), (pre + DP > 1023) ? 1023 : pre + DP);
            check("hit_expire.slot", 32'(orders[s]), 0);
        end

        // Let remaining orders age out
        for (int t = 0; t < 35; t++) tick_once("drain");

        // Reset mid-game loses slots and score
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        check("midreset.orders", 32'(orders), 0);
        check("midreset.score", 32'(point_total), 0);
        check("midreset.times", 32'(order_times), 0);
        tick_once("post_reset");
        check("post_reset.mask", 32'(orders), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
